// File: rtl/genius_pkg.sv
// Shared types and helpers for the Genius round sequencer.
package genius_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SHOW_ON,
    ST_SHOW_OFF,
    ST_WAIT_PRESS,
    ST_WAIT_RELEASE,
    ST_ADVANCE
  } state_t;

  localparam logic [1:0] SYM_ZERO = 2'd0;
  localparam logic [1:0] SYM_ONE  = 2'd1;
  localparam logic [1:0] SYM_TWO  = 2'd2;
  localparam logic [1:0] INVALID  = 2'd3;

  // Button pattern a correct press must produce; INVALID maps to no buttons,
  // so any press against it is a mismatch.
  function automatic logic [2:0] sym_to_onehot(input logic [1:0] sym);
    logic [2:0] onehot;
    case (sym)
      SYM_ZERO: onehot = 3'b001;
      SYM_ONE:  onehot = 3'b010;
      SYM_TWO:  onehot = 3'b100;
      default:  onehot = 3'b000;
    endcase
    return onehot;
  endfunction

endpackage

// File: rtl/genius_round_ctrl_timer.sv
// Loadable down-counter shared by the show, gap and press-timeout phases.
// A phase of N cycles is loaded with N-1 on entry; done marks its last cycle.
module genius_cycle_timer #(
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             enable,
  output logic             done
);

  logic [WIDTH-1:0] count;

  // Load has priority; otherwise count down and park at zero.
  always_ff @(posedge clock) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (enable && (count != '0)) begin
      count <= count - WIDTH'(1);
    end
  end

  assign done = (count == '0);

endmodule

// File: rtl/genius_round_ctrl.sv
// Genius round sequencer: plays back the pattern for the current level,
// then checks one debounced button press per symbol with a press timeout.
//
// state           | meaning
// ST_IDLE         | waiting for a start rising edge
// ST_SHOW_ON      | symbol at step displayed for ON_CYCLES
// ST_SHOW_OFF     | blank gap for OFF_CYCLES after each symbol
// ST_WAIT_PRESS   | waiting for a press event, timeout running
// ST_WAIT_RELEASE | correct press seen, waiting for all buttons released
// ST_ADVANCE      | round complete, win or move to next level
module genius_round_ctrl
  import genius_pkg::*;
#(
  parameter int MAX_LEVEL      = 16,
  parameter int ON_CYCLES      = 12_500_000,
  parameter int OFF_CYCLES     = 6_250_000,
  parameter int TIMEOUT_CYCLES = 150_000_000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic [2:0] btn,
  output logic [3:0] pat_addr,
  input  logic [1:0] pat_data,
  output logic       show_valid,
  output logic [1:0] show_sym,
  output logic [3:0] level,
  output logic [3:0] step,
  output logic       busy,
  output logic       win,
  output logic       fail
);

  localparam int MAX_A   = (ON_CYCLES > OFF_CYCLES) ? ON_CYCLES : OFF_CYCLES;
  localparam int MAX_CYC = (MAX_A > TIMEOUT_CYCLES) ? MAX_A : TIMEOUT_CYCLES;
  localparam int CNT_W   = (MAX_CYC > 2) ? $clog2(MAX_CYC) : 1;
  localparam logic [3:0] LAST_LEVEL = 4'(MAX_LEVEL - 1);

  state_t           state;
  state_t           next_state;
  logic             start_q;
  logic [2:0]       btn_q;
  logic             start_evt;
  logic             press_evt;
  logic             step_last;
  logic             fail_set;
  logic             win_set;
  logic             t_load;
  logic             t_enable;
  logic [CNT_W-1:0] t_load_value;
  logic             t_done;

  assign start_evt = start && !start_q;
  assign press_evt = (btn != 3'b000) && (btn_q == 3'b000);
  assign step_last = (step == level);
  assign pat_addr  = step;

  genius_cycle_timer #(
    .WIDTH(CNT_W)
  ) u_timer (
    .clock     (clock),
    .reset     (reset),
    .load      (t_load),
    .load_value(t_load_value),
    .enable    (t_enable),
    .done      (t_done)
  );

  // State register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic and end-of-game verdicts; a press beats a same-cycle timeout.
  always_comb begin
    next_state = state;
    fail_set   = 1'b0;
    win_set    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start_evt) next_state = ST_SHOW_ON;
      end
      ST_SHOW_ON: begin
        if (t_done) next_state = ST_SHOW_OFF;
      end
      ST_SHOW_OFF: begin
        if (t_done) next_state = step_last ? ST_WAIT_PRESS : ST_SHOW_ON;
      end
      ST_WAIT_PRESS: begin
        if (press_evt) begin
          if (btn == sym_to_onehot(pat_data)) begin
            next_state = ST_WAIT_RELEASE;
          end else begin
            fail_set   = 1'b1;
            next_state = ST_IDLE;
          end
        end else if (t_done) begin
          fail_set   = 1'b1;
          next_state = ST_IDLE;
        end
      end
      ST_WAIT_RELEASE: begin
        if (btn == 3'b000) next_state = step_last ? ST_ADVANCE : ST_WAIT_PRESS;
      end
      ST_ADVANCE: begin
        if (level == LAST_LEVEL) begin
          win_set    = 1'b1;
          next_state = ST_IDLE;
        end else begin
          next_state = ST_SHOW_ON;
        end
      end
      default: next_state = ST_IDLE;
    endcase
  end

  // Timer reload on every state entry with the duration of the state being entered.
  always_comb begin
    t_load       = (next_state != state);
    t_enable     = (state == ST_SHOW_ON) || (state == ST_SHOW_OFF) ||
                   (state == ST_WAIT_PRESS);
    t_load_value = '0;
    case (next_state)
      ST_SHOW_ON:    t_load_value = CNT_W'(ON_CYCLES - 1);
      ST_SHOW_OFF:   t_load_value = CNT_W'(OFF_CYCLES - 1);
      ST_WAIT_PRESS: t_load_value = CNT_W'(TIMEOUT_CYCLES - 1);
      default:       t_load_value = '0;
    endcase
  end

  // Output decode from the registered state.
  always_comb begin
    show_valid = (state == ST_SHOW_ON);
    busy       = (state != ST_IDLE);
    show_sym   = show_valid ? pat_data : 2'd0;
  end

  // Level/step bookkeeping, input edge history and one-cycle verdict pulses.
  always_ff @(posedge clock) begin
    if (reset) begin
      level   <= 4'd0;
      step    <= 4'd0;
      start_q <= 1'b0;
      btn_q   <= 3'b000;
      win     <= 1'b0;
      fail    <= 1'b0;
    end else begin
      start_q <= start;
      btn_q   <= btn;
      win     <= win_set;
      fail    <= fail_set;
      case (state)
        ST_IDLE: begin
          if (start_evt) begin
            level <= 4'd0;
            step  <= 4'd0;
          end
        end
        ST_SHOW_OFF: begin
          if (t_done) step <= step_last ? 4'd0 : step + 4'd1;
        end
        ST_WAIT_RELEASE: begin
          if ((btn == 3'b000) && !step_last) step <= step + 4'd1;
        end
        ST_ADVANCE: begin
          if (level != LAST_LEVEL) begin
            level <= level + 4'd1;
            step  <= 4'd0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
